bcd_6d_to_binary_20b: RTL and testbench

//   Multi-cycle converter from packed 6-digit BCD to 20-bit binary, the inverse of the

---
 rtl/bcd_6d_to_binary_20b_if.sv | 23 ++
 rtl/bcd_6d_to_binary_20b.sv | 131 +++++++++++++
 tb/tb_bcd_6d_to_binary_20b.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_6d_to_binary_20b_if.sv
// Handshake and data bundle for the BCD-to-binary converter.
// The master side requests conversions; the slave side is the converter itself.
interface bcd_6d_to_binary_20b_if #(
    parameter int DIGITS = 6,
    parameter int BW     = 20
);
    logic                  start_i;
    logic [4*DIGITS-1:0]   bcd_i;
    logic                  busy_o;
    logic                  done_o;
    logic                  err_o;
    logic [BW-1:0]         bin_o;

    modport master (
        output start_i, bcd_i,
        input  busy_o, done_o, err_o, bin_o
    );

    modport slave (
        input  start_i, bcd_i,
        output busy_o, done_o, err_o, bin_o
    );
endinterface

// File: rtl/bcd_6d_to_binary_20b.sv
// Multi-cycle packed-BCD to binary converter using reverse double-dabble:
// shift the working register right, then subtract 3 from every BCD field >= 8.
module bcd_6d_to_binary_20b #(
    parameter int DIGITS = 6,
    parameter int BW     = 20
) (
    input  logic                    clk,
    input  logic                    rstn,
    bcd_6d_to_binary_20b_if.slave   bus
);
    localparam int WW = 4*DIGITS + BW;
    localparam int CW = $clog2(BW);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [WW-1:0] w_q, w_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pend_q, pend_d;
    logic [BW-1:0] bin_q, bin_d;

    logic [WW-1:0] w_shift;
    logic [WW-1:0] w_fix;
    logic          bad_digit;

    // One reverse double-dabble step applied to the current working register.
    always_comb begin
        logic [3:0] digit;
        digit   = '0;
        w_shift = w_q >> 1;
        w_fix   = w_shift;
        for (int k = 0; k < DIGITS; k++) begin
            digit = w_shift[BW+4*k +: 4];
            if (digit >= 4'd8) begin
                w_fix[BW+4*k +: 4] = digit - 4'd3;
            end
        end
    end

    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (bus.bcd_i[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end

    // An invalid request is remembered for one cycle so its done pulse lands on the next edge.
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pend_d  = 1'b0;
        bin_d   = bin_q;
        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    done_d = 1'b1;
                    err_d  = 1'b1;
                    bin_d  = '0;
                end else if (bus.start_i) begin
                    if (bad_digit) begin
                        pend_d = 1'b1;
                    end else begin
                        w_d     = {bus.bcd_i, {BW{1'b0}}};
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                w_d   = w_fix;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BW-1)) begin
                    bin_d   = w_fix[BW-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            w_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pend_q  <= 1'b0;
            bin_q   <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pend_q  <= pend_d;
            bin_q   <= bin_d;
        end
    end

    // After the final step every BCD field must have drained to zero.
    always @(posedge clk) begin
        if (rstn && state_q == SHIFT && cnt_q == CW'(BW-1)) begin
            assert (w_fix[WW-1:BW] == '0);
        end
    end

    assign bus.busy_o = busy_q;
    assign bus.done_o = done_q;
    assign bus.err_o  = err_q;
    assign bus.bin_o  = bin_q;
endmodule

// File: tb/tb_bcd_6d_to_binary_20b.sv
// Directed and randomized bench for the BCD-to-binary converter, checked against
// a decimal reference model.
module tb_bcd_6d_to_binary_20b;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    bcd_6d_to_binary_20b_if #(.DIGITS(6), .BW(20)) bus ();

    bcd_6d_to_binary_20b #(.DIGITS(6), .BW(20)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: digits interpreted as a decimal number; any digit above 9 invalidates it.
    function automatic int ref_value(input logic [23:0] bcd, output bit valid);
        int v;
        logic [3:0] d;
        v = 0;
        valid = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            if (d > 4'd9) valid = 1'b0;
            v = v * 10 + int'(d);
        end
        return valid ? v : 0;
    endfunction

    function automatic logic [23:0] to_bcd(input int n);
        string s;
        logic [23:0] b;
        s = $sformatf("%06d", n);
        b = '0;
        for (int i = 0; i < 6; i++) begin
            b[4*(5-i) +: 4] = 4'(s[i] - "0");
        end
        return b;
    endfunction

    // Request one conversion; bcd_i is scrambled after acceptance to show it is captured.
    task automatic start_conv(input logic [23:0] bcd);
        @(negedge clk);
        bus.bcd_i   = bcd;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.bcd_i   = 24'($urandom);
    endtask

    // Samples just after edges E0..E(window); optional start injection after edge inj_k.
    task automatic observe(input int window, input int inj_k, input logic [23:0] inj_bcd,
                           output int first, output int last, output int count, output int busy_cnt);
        first = -1;
        last = -1;
        count = 0;
        busy_cnt = 0;
        for (int k = 0; k <= window; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
                if (inj_k >= 0 && k == inj_k + 1) bus.start_i = 1'b0;
            end
            if (bus.busy_o) busy_cnt++;
            if (bus.done_o) begin
                count++;
                last = k;
                if (first < 0) first = k;
            end
            if (k == inj_k) begin
                bus.bcd_i   = inj_bcd;
                bus.start_i = 1'b1;
            end
        end
    endtask

    initial begin
        int first, last, count, busy_cnt, expv, n, pos;
        bit valid;
        logic [23:0] bcd;

        checks = 0;
        errors = 0;
        bus.start_i = 1'b0;
        bus.bcd_i   = '0;
        rstn = 1'b0;
        #12;
        check("reset_busy", 32'(bus.busy_o), 0);
        check("reset_done", 32'(bus.done_o), 0);
        check("reset_err",  32'(bus.err_o), 0);
        check("reset_bin",  32'(bus.bin_o), 0);
        @(negedge clk);
        rstn = 1'b1;

        // 1: maximum value
        start_conv(24'h999999);
        observe(24, -1, '0, first, last, count, busy_cnt);
        check("max_latency", 32'(first), 20);
        check("max_count", 32'(count), 1);
        check("max_busy_cycles", 32'(busy_cnt), 20);
        check("max_bin", 32'(bus.bin_o), 32'(ref_value(24'h999999, valid)));
        check("max_bin_const", 32'(bus.bin_o), 32'h000F423F);
        check("max_err", 32'(bus.err_o), 0);

        // 2: small values
        start_conv(24'h000000);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("zero_bin", 32'(bus.bin_o), 0);
        check("zero_latency", 32'(first), 20);
        start_conv(24'h000010);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("ten_bin", 32'(bus.bin_o), 10);
        start_conv(24'h000002);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("two_bin", 32'(bus.bin_o), 2);

        // 3: invalid digit, then recovery
        start_conv(24'h12A456);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("inv_latency", 32'(first), 1);
        check("inv_count", 32'(count), 1);
        check("inv_busy_cycles", 32'(busy_cnt), 0);
        check("inv_err", 32'(bus.err_o), 1);
        check("inv_bin", 32'(bus.bin_o), 0);
        start_conv(24'h000007);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("rec_err", 32'(bus.err_o), 0);
        check("rec_bin", 32'(bus.bin_o), 7);

        // 4: start while busy is ignored
        start_conv(24'h123456);
        observe(26, 4, 24'h000001, first, last, count, busy_cnt);
        check("busy_ign_count", 32'(count), 1);
        check("busy_ign_latency", 32'(first), 20);
        check("busy_ign_bin", 32'(bus.bin_o), 123456);

        // 5: reset mid-conversion
        start_conv(24'h654321);
        observe(9, -1, '0, first, last, count, busy_cnt);
        check("pre_rst_busy", 32'(bus.busy_o), 1);
        rstn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(bus.busy_o), 0);
        check("mid_rst_done", 32'(bus.done_o), 0);
        check("mid_rst_bin", 32'(bus.bin_o), 0);
        check("mid_rst_err", 32'(bus.err_o), 0);
        @(negedge clk);
        rstn = 1'b1;
        observe(25, -1, '0, first, last, count, busy_cnt);
        check("post_rst_no_done", 32'(count), 0);
        start_conv(24'h000100);
        observe(22, -1, '0, first, last, count, busy_cnt);
        check("post_rst_bin", 32'(bus.bin_o), 100);

        // 6: start held high gives back-to-back conversions every 21 cycles
        @(negedge clk);
        bus.bcd_i   = 24'h500000;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        observe(64, -1, '0, first, last, count, busy_cnt);
        check("b2b_first", 32'(first), 20);
        check("b2b_last", 32'(last), 62);
        check("b2b_count", 32'(count), 3);
        check("b2b_bin", 32'(bus.bin_o), 500000);
        bus.start_i = 1'b0;
        observe(25, -1, '0, first, last, count, busy_cnt);
        check("b2b_drain_bin", 32'(bus.bin_o), 500000);

        // Random valid values through the decimal reference
        for (int t = 0; t < 120; t++) begin
            n = int'($urandom_range(0, 999999));
            bcd = to_bcd(n);
            expv = ref_value(bcd, valid);
            start_conv(bcd);
            observe(21, -1, '0, first, last, count, busy_cnt);
            check("rnd_latency", 32'(first), 20);
            check("rnd_bin", 32'(bus.bin_o), 32'(expv));
            check("rnd_err", 32'(bus.err_o), 0);
        end

        // Random inputs with one corrupted digit
        for (int t = 0; t < 20; t++) begin
            bcd = to_bcd(int'($urandom_range(0, 999999)));
            pos = int'($urandom_range(0, 5));
            bcd[4*pos +: 4] = 4'($urandom_range(10, 15));
            expv = ref_value(bcd, valid);
            start_conv(bcd);
            observe(3, -1, '0, first, last, count, busy_cnt);
            check("rnd_inv_latency", 32'(first), 1);
            check("rnd_inv_err", 32'(bus.err_o), 32'(!valid));
            check("rnd_inv_bin", 32'(bus.bin_o), 32'(expv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
